// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Define MDU_DIV_EN to include the restoring divider and DIV/DIVU support.
module mult_div_unit #(
    parameter int BIT_WIDTH = 32,
    parameter int CNT_WIDTH = $clog2(BIT_WIDTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [2:0]           op_i,
    input  logic [BIT_WIDTH-1:0] operandA_i,
    input  logic [BIT_WIDTH-1:0] operandB_i,
    output logic [BIT_WIDTH-1:0] hi_o,
    output logic [BIT_WIDTH-1:0] lo_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 divByZero_o
);
    localparam int W = BIT_WIDTH;
    localparam logic [2:0] OP_MULT = 3'b000;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]       acc_q, acc_d;
    logic [W-1:0]         opnd_q, opnd_d;
    logic [W-1:0]         hi_q, hi_d, lo_q, lo_d;
    logic                 busy_q, busy_d, done_q, done_d, negRes_q, negRes_d;

    logic                 isSigned, signA, signB, launch;
    logic [W-1:0]         absA, absB;
    logic [W:0]           mulSum;
    logic [2*W-1:0]       mulNext, product;

`ifdef MDU_DIV_EN
    logic                 isDiv_q, isDiv_d, negRem_q, negRem_d;
    logic                 zeroDiv_q, zeroDiv_d, dbz_q, dbz_d;
    logic [W-1:0]         aRaw_q, aRaw_d;
    logic [W:0]           remShift;
    logic                 divGe;
    logic [W-1:0]         remDiff, remNew, quo, rem;
    logic [2*W-1:0]       divNext;

    assign launch = (op_i[2] == 1'b0);
`else
    assign launch = (op_i[2:1] == 2'b00);
`endif

    // Signed ops run on magnitudes; the signs are reapplied in FIXUP.
    assign isSigned = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign signA    = isSigned & operandA_i[W-1];
    assign signB    = isSigned & operandB_i[W-1];
    assign absA     = signA ? -operandA_i : operandA_i;
    assign absB     = signB ? -operandB_i : operandB_i;

    assign mulSum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
    assign mulNext  = {mulSum, acc_q[W-1:1]};
    assign product  = negRes_q ? -acc_q : acc_q;

`ifdef MDU_DIV_EN
    // Restoring step: remainder in the upper half, quotient shifts into the lower half.
    assign remShift = {acc_q[2*W-1:W], acc_q[W-1]};
    assign divGe    = remShift >= {1'b0, opnd_q};
    assign remDiff  = remShift[W-1:0] - opnd_q;
    assign remNew   = divGe ? remDiff : remShift[W-1:0];
    assign divNext  = {remNew, acc_q[W-2:0], divGe};
    assign quo      = negRes_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    assign rem      = negRem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    assign divByZero_o = dbz_q;
`else
    assign divByZero_o = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        negRes_d = negRes_q;
`ifdef MDU_DIV_EN
        isDiv_d   = isDiv_q;
        negRem_d  = negRem_q;
        zeroDiv_d = zeroDiv_q;
        aRaw_d    = aRaw_q;
        dbz_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start_i && launch) begin
                    acc_d    = {{W{1'b0}}, absA};
                    opnd_d   = absB;
                    negRes_d = signA ^ signB;
                    cnt_d    = CNT_WIDTH'(W - 1);
                    busy_d   = 1'b1;
                    state_d  = CALC;
`ifdef MDU_DIV_EN
                    isDiv_d   = op_i[1];
                    negRem_d  = signA;
                    zeroDiv_d = (operandB_i == {W{1'b0}});
                    aRaw_d    = operandA_i;
`endif
                end else if (start_i && op_i == OP_MTHI) begin
                    hi_d = operandA_i;
                end else if (start_i && op_i == OP_MTLO) begin
                    lo_d = operandA_i;
                end
            end
            CALC: begin
`ifdef MDU_DIV_EN
                acc_d = isDiv_q ? divNext : mulNext;
`else
                acc_d = mulNext;
`endif
                if (cnt_q == '0) begin
                    state_d = FIXUP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            FIXUP: begin
                hi_d = product[2*W-1:W];
                lo_d = product[W-1:0];
`ifdef MDU_DIV_EN
                if (isDiv_q && zeroDiv_q) begin
                    hi_d  = aRaw_q;
                    lo_d  = {W{1'b1}};
                    dbz_d = 1'b1;
                end else if (isDiv_q) begin
                    hi_d = rem;
                    lo_d = quo;
                end
`endif
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            negRes_q <= 1'b0;
`ifdef MDU_DIV_EN
            isDiv_q   <= 1'b0;
            negRem_q  <= 1'b0;
            zeroDiv_q <= 1'b0;
            aRaw_q    <= '0;
            dbz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            negRes_q <= negRes_d;
`ifdef MDU_DIV_EN
            isDiv_q   <= isDiv_d;
            negRem_q  <= negRem_d;
            zeroDiv_q <= zeroDiv_d;
            aRaw_q    <= aRaw_d;
            dbz_q     <= dbz_d;
`endif
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit; divide scenarios follow MDU_DIV_EN.
module tb_mult_div_unit;
    logic        clk;
    logic        rstN;
    logic        startI;
    logic [2:0]  opI;
    logic [31:0] aI, bI;
    logic [31:0] hiO, loO;
    logic        busyO, doneO, dbzO;

    int passCount;
    int checkCount;

    mult_div_unit #(.BIT_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rstN), .start_i(startI), .op_i(opI),
        .operandA_i(aI), .operandB_i(bI), .hi_o(hiO), .lo_o(loO),
        .busy_o(busyO), .done_o(doneO), .divByZero_o(dbzO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launches one op from a post-edge time and waits (bounded) for Done.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output int lat, output int busyCyc);
        startI = 1'b1; opI = op; aI = a; bI = b;
        @(posedge clk); #1;
        startI = 1'b0;
        lat = 0;
        busyCyc = 0;
        while (!doneO && lat < 60) begin
            if (busyO) busyCyc++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rstN = 1'b0; startI = 1'b0; opI = 3'b000; aI = '0; bI = '0;
        repeat (2) @(posedge clk);
        #1;
        checkCount++; if (hiO !== 32'h0) $display("[TB] FAIL reset_hi got %h want 0", hiO); else passCount++;
        checkCount++; if (loO !== 32'h0) $display("[TB] FAIL reset_lo got %h want 0", loO); else passCount++;
        checkCount++; if (busyO !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busyO); else passCount++;
        checkCount++; if (doneO !== 1'b0) $display("[TB] FAIL reset_done got %b want 0", doneO); else passCount++;
        checkCount++; if (dbzO !== 1'b0) $display("[TB] FAIL reset_dbz got %b want 0", dbzO); else passCount++;
        rstN = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_multu();
        int lat, busyCyc;
        applyStimulus(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, busyCyc);
        checkCount++; if (lat !== 33) $display("[TB] FAIL multu_latency got %0d want 33", lat); else passCount++;
        checkCount++; if (busyCyc !== 33) $display("[TB] FAIL multu_busy_cycles got %0d want 33", busyCyc); else passCount++;
        checkCount++; if (hiO !== 32'hFFFFFFFE) $display("[TB] FAIL multu_hi got %h want fffffffe", hiO); else passCount++;
        checkCount++; if (loO !== 32'h00000001) $display("[TB] FAIL multu_lo got %h want 00000001", loO); else passCount++;
        checkCount++; if (busyO !== 1'b0) $display("[TB] FAIL multu_busy_at_done got %b want 0", busyO); else passCount++;
        checkCount++; if (dbzO !== 1'b0) $display("[TB] FAIL multu_dbz got %b want 0", dbzO); else passCount++;
        @(posedge clk); #1;
        checkCount++; if (doneO !== 1'b0) $display("[TB] FAIL multu_done_one_cycle got %b want 0", doneO); else passCount++;
        checkCount++; if (hiO !== 32'hFFFFFFFE) $display("[TB] FAIL multu_hi_hold got %h want fffffffe", hiO); else passCount++;
    endtask

    task automatic test_mult();
        logic [2:0]  opV  [5] = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000};
        logic [31:0] aV   [5] = '{32'hFFFFFFFD, 32'h80000000, 32'h12345678, 32'h00000007, 32'h00000000};
        logic [31:0] bV   [5] = '{32'h00000005, 32'h80000000, 32'h00000010, 32'hFFFFFFF7, 32'hFFFFFFFF};
        logic [31:0] hiV  [5] = '{32'hFFFFFFFF, 32'h40000000, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
        logic [31:0] loV  [5] = '{32'hFFFFFFF1, 32'h00000000, 32'h23456780, 32'hFFFFFFC1, 32'h00000000};
        int lat, busyCyc;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(opV[i], aV[i], bV[i], lat, busyCyc);
            checkCount++; if (lat !== 33) $display("[TB] FAIL mult%0d_latency got %0d want 33", i, lat); else passCount++;
            checkCount++; if (hiO !== hiV[i]) $display("[TB] FAIL mult%0d_hi got %h want %h", i, hiO, hiV[i]); else passCount++;
            checkCount++; if (loO !== loV[i]) $display("[TB] FAIL mult%0d_lo got %h want %h", i, loO, loV[i]); else passCount++;
        end
    endtask

    task automatic test_mthi_mtlo();
        startI = 1'b1; opI = 3'b100; aI = 32'h12345678; bI = 32'h0;
        @(posedge clk); #1;
        checkCount++; if (hiO !== 32'h12345678) $display("[TB] FAIL mthi_hi got %h want 12345678", hiO); else passCount++;
        checkCount++; if (busyO !== 1'b0 || doneO !== 1'b0) $display("[TB] FAIL mthi_busy_done got %b%b want 00", busyO, doneO); else passCount++;
        opI = 3'b101; aI = 32'h9ABCDEF0;
        @(posedge clk); #1;
        checkCount++; if (loO !== 32'h9ABCDEF0) $display("[TB] FAIL mtlo_lo got %h want 9abcdef0", loO); else passCount++;
        checkCount++; if (hiO !== 32'h12345678) $display("[TB] FAIL mtlo_hi_kept got %h want 12345678", hiO); else passCount++;
        checkCount++; if (busyO !== 1'b0 || doneO !== 1'b0) $display("[TB] FAIL mtlo_busy_done got %b%b want 00", busyO, doneO); else passCount++;
        opI = 3'b110; aI = 32'hDEADBEEF;
        @(posedge clk); #1;
        opI = 3'b111;
        @(posedge clk); #1;
        startI = 1'b0;
        checkCount++; if (hiO !== 32'h12345678 || loO !== 32'h9ABCDEF0)
            $display("[TB] FAIL reserved_op got %h_%h want 12345678_9abcdef0", hiO, loO); else passCount++;
        checkCount++; if (busyO !== 1'b0) $display("[TB] FAIL reserved_busy got %b want 0", busyO); else passCount++;
    endtask

`ifdef MDU_DIV_EN
    task automatic test_div();
        logic [2:0]  opV  [6] = '{3'b010, 3'b010, 3'b011, 3'b011, 3'b010, 3'b010};
        logic [31:0] aV   [6] = '{32'hFFFFFFF9, 32'h00000007, 32'd100, 32'h00000064, 32'h80000000, 32'hFFFFFFFB};
        logic [31:0] bV   [6] = '{32'h00000002, 32'hFFFFFFFE, 32'd7, 32'h00000000, 32'hFFFFFFFF, 32'h00000000};
        logic [31:0] hiV  [6] = '{32'hFFFFFFFF, 32'h00000001, 32'd2, 32'h00000064, 32'h00000000, 32'hFFFFFFFB};
        logic [31:0] loV  [6] = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'd14, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        logic        dbzV [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int lat, busyCyc;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(opV[i], aV[i], bV[i], lat, busyCyc);
            checkCount++; if (lat !== 33) $display("[TB] FAIL div%0d_latency got %0d want 33", i, lat); else passCount++;
            checkCount++; if (hiO !== hiV[i]) $display("[TB] FAIL div%0d_hi got %h want %h", i, hiO, hiV[i]); else passCount++;
            checkCount++; if (loO !== loV[i]) $display("[TB] FAIL div%0d_lo got %h want %h", i, loO, loV[i]); else passCount++;
            checkCount++; if (dbzO !== dbzV[i]) $display("[TB] FAIL div%0d_dbz got %b want %b", i, dbzO, dbzV[i]); else passCount++;
            @(posedge clk); #1;
            checkCount++; if (dbzO !== 1'b0) $display("[TB] FAIL div%0d_dbz_pulse got %b want 0", i, dbzO); else passCount++;
        end
    endtask
`else
    task automatic test_div_disabled();
        int doneSeen;
        startI = 1'b1; opI = 3'b011; aI = 32'd100; bI = 32'd7;
        @(posedge clk); #1;
        startI = 1'b0;
        checkCount++; if (busyO !== 1'b0) $display("[TB] FAIL divoff_busy got %b want 0", busyO); else passCount++;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (doneO || dbzO) doneSeen++;
        end
        checkCount++; if (doneSeen !== 0) $display("[TB] FAIL divoff_done got %0d pulses want 0", doneSeen); else passCount++;
        checkCount++; if (hiO !== 32'h12345678 || loO !== 32'h9ABCDEF0)
            $display("[TB] FAIL divoff_hilo got %h_%h want 12345678_9abcdef0", hiO, loO); else passCount++;
    endtask
`endif

    task automatic test_back_to_back();
        int lat, busyCyc;
        startI = 1'b1; opI = 3'b001; aI = 32'd3; bI = 32'd5;
        @(posedge clk); #1;
        startI = 1'b0;
        lat = 0;
        repeat (5) begin @(posedge clk); #1; lat++; end
        startI = 1'b1; opI = 3'b000; aI = 32'd100; bI = 32'd200;
        repeat (2) begin @(posedge clk); #1; lat++; end
        startI = 1'b0;
        while (!doneO && lat < 60) begin @(posedge clk); #1; lat++; end
        checkCount++; if (lat !== 33) $display("[TB] FAIL b2b_latency got %0d want 33", lat); else passCount++;
        checkCount++; if (hiO !== 32'd0 || loO !== 32'd15) $display("[TB] FAIL b2b_result got %h_%h want 00000000_0000000f", hiO, loO); else passCount++;
        applyStimulus(3'b001, 32'd6, 32'd7, lat, busyCyc);
        checkCount++; if (lat !== 33) $display("[TB] FAIL b2b_next_latency got %0d want 33", lat); else passCount++;
        checkCount++; if (hiO !== 32'd0 || loO !== 32'd42) $display("[TB] FAIL b2b_next_result got %h_%h want 00000000_0000002a", hiO, loO); else passCount++;
    endtask

    task automatic test_reset_abort();
        int doneSeen, lat, busyCyc;
        startI = 1'b1; opI = 3'b001; aI = 32'd7; bI = 32'd9;
        @(posedge clk); #1;
        startI = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rstN = 1'b0;
        #1;
        checkCount++; if (hiO !== 32'd0 || loO !== 32'd0) $display("[TB] FAIL abort_hilo got %h_%h want 0_0", hiO, loO); else passCount++;
        checkCount++; if (busyO !== 1'b0) $display("[TB] FAIL abort_busy got %b want 0", busyO); else passCount++;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (doneO || busyO) doneSeen++;
        end
        checkCount++; if (doneSeen !== 0) $display("[TB] FAIL abort_no_done got %0d active cycles want 0", doneSeen); else passCount++;
        checkCount++; if (hiO !== 32'd0 || loO !== 32'd0) $display("[TB] FAIL abort_no_commit got %h_%h want 0_0", hiO, loO); else passCount++;
        applyStimulus(3'b001, 32'd7, 32'd9, lat, busyCyc);
        checkCount++; if (lat !== 33) $display("[TB] FAIL rerun_latency got %0d want 33", lat); else passCount++;
        checkCount++; if (hiO !== 32'd0 || loO !== 32'd63) $display("[TB] FAIL rerun_result got %h_%h want 00000000_0000003f", hiO, loO); else passCount++;
    endtask

    initial begin
        passCount = 0;
        checkCount = 0;
        test_reset();
        test_multu();
        test_mult();
        test_mthi_mtlo();
`ifdef MDU_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_back_to_back();
        test_reset_abort();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
